filter_sobel_3x3: RTL and testbench

Sobel edge-magnitude stage directly downstream of the 3x3 window core. It consumes the nine-pixel window (x1..x9) plus de/hs/vs, computes |Gx|+|Gy| in a fixed 4-stage pipeline, scales and saturates the result, and flags pixels above a runtime threshold. It also tracks the per-frame maximum magnitude for exposure/AGC software.

---
 rtl/filter_sobel_3x3.sv | 130 +++++++++++++
 tb/tb_filter_sobel_3x3.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/filter_sobel_3x3.sv
// Sobel |Gx|+|Gy| edge-magnitude stage with thresholded edge flag
// and per-frame peak-magnitude tracking.
module filter_sobel_3x3 #(
  parameter int DATA_WIDTH = 12,
  parameter int MAG_SHIFT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [DATA_WIDTH-1:0] x1,
  input  logic [DATA_WIDTH-1:0] x2,
  input  logic [DATA_WIDTH-1:0] x3,
  input  logic [DATA_WIDTH-1:0] x4,
  input  logic [DATA_WIDTH-1:0] x5,
  input  logic [DATA_WIDTH-1:0] x6,
  input  logic [DATA_WIDTH-1:0] x7,
  input  logic [DATA_WIDTH-1:0] x8,
  input  logic [DATA_WIDTH-1:0] x9,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  edge_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic [DATA_WIDTH-1:0] frame_max_o,
  output logic                  frame_max_vld
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = W + 2;
  localparam int GW = W + 3;
  localparam logic [W-1:0] MAXV = '1;

  typedef enum logic [1:0] {WAIT_LOW, ARMED, IN_FRAME} state_t;

  logic [SW-1:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [GW-1:0]        mag_q, mag_d;
  logic [W-1:0]         x5_1_q, x5_1_d, x5_2_q, x5_2_d, x5_3_q, x5_3_d;
  logic [2:0]           c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, c4_q, c4_d;
  logic [W-1:0]         do_q, do_d;
  logic                 edge_q, edge_d;
  logic [W-1:0]         run_q, run_d, fmax_q, fmax_d;
  logic                 vld_q, vld_d;
  state_t               st_q, st_d;

  logic [GW-1:0] ax, ay, m;
  logic [W-1:0]  sat;

  always_comb begin
    a_d = {2'b0, x3} + {1'b0, x6, 1'b0} + {2'b0, x9};
    b_d = {2'b0, x1} + {1'b0, x4, 1'b0} + {2'b0, x7};
    c_d = {2'b0, x7} + {1'b0, x8, 1'b0} + {2'b0, x9};
    d_d = {2'b0, x1} + {1'b0, x2, 1'b0} + {2'b0, x3};
    gx_d = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
    gy_d = $signed({1'b0, c_q}) - $signed({1'b0, d_q});
    ax = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag_d = ax + ay;
    x5_1_d = x5;
    x5_2_d = x5_1_q;
    x5_3_d = x5_2_q;
    c1_d = {de_i, hs_i, vs_i};
    c2_d = c1_q;
    c3_d = c2_q;
    c4_d = c3_q;
    m   = mag_q >> MAG_SHIFT;
    sat = (m > {{(GW-W){1'b0}}, MAXV}) ? MAXV : m[W-1:0];
    do_d   = bypass ? x5_3_q : sat;
    edge_d = !bypass && c3_q[2] && (do_d > threshold);
  end

  // FSM looks at the S4 register inputs so frame_max_o/vld land
  // on the same clock as the vs_o falling edge they report.
  always_comb begin
    st_d   = st_q;
    run_d  = run_q;
    fmax_d = fmax_q;
    vld_d  = 1'b0;
    unique case (st_q)
      WAIT_LOW: if (!vs_i) st_d = ARMED;
      ARMED: begin
        if (c3_q[0] && !c4_q[0]) begin
          st_d  = IN_FRAME;
          run_d = c3_q[2] ? do_d : '0;
        end
      end
      IN_FRAME: begin
        if (!c3_q[0] && c4_q[0]) begin
          fmax_d = run_q;
          vld_d  = 1'b1;
          st_d   = ARMED;
        end else if (c3_q[0] && c3_q[2] && do_d > run_q) begin
          run_d = do_d;
        end
      end
      default: st_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      gx_q <= '0; gy_q <= '0; mag_q <= '0;
      x5_1_q <= '0; x5_2_q <= '0; x5_3_q <= '0;
      c1_q <= '0; c2_q <= '0; c3_q <= '0; c4_q <= '0;
      do_q <= '0; edge_q <= 1'b0;
      run_q <= '0; fmax_q <= '0; vld_q <= 1'b0;
      st_q <= WAIT_LOW;
    end else begin
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      gx_q <= gx_d; gy_q <= gy_d; mag_q <= mag_d;
      x5_1_q <= x5_1_d; x5_2_q <= x5_2_d; x5_3_q <= x5_3_d;
      c1_q <= c1_d; c2_q <= c2_d; c3_q <= c3_d; c4_q <= c4_d;
      do_q <= do_d; edge_q <= edge_d;
      run_q <= run_d; fmax_q <= fmax_d; vld_q <= vld_d;
      st_q <= st_d;
    end
  end

  assign do_o          = do_q;
  assign edge_o        = edge_q;
  assign de_o          = c4_q[2];
  assign hs_o          = c4_q[1];
  assign vs_o          = c4_q[0];
  assign frame_max_o   = fmax_q;
  assign frame_max_vld = vld_q;
endmodule

// File: tb/tb_filter_sobel_3x3.sv
// Directed bench for filter_sobel_3x3: magnitude, saturation,
// bypass latency, edge threshold and frame-max reporting.
module tb_filter_sobel_3x3;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bypass = 1'b0;
  logic [W-1:0] threshold = '0;
  logic [W-1:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0, x5 = '0;
  logic [W-1:0] x6 = '0, x7 = '0, x8 = '0, x9 = '0;
  logic         de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;

  logic [W-1:0] do_o, fmax;
  logic         edge_o, de_o, hs_o, vs_o, fvld;
  logic [W-1:0] do_s0, fmax_s0, do_s3, fmax_s3;
  logic         e_s0, de_s0, hs_s0, vs_s0, fv_s0;
  logic         e_s3, de_s3, hs_s3, vs_s3, fv_s3;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  filter_sobel_3x3 #(.DATA_WIDTH(W), .MAG_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .bypass(bypass), .threshold(threshold),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5),
    .x6(x6), .x7(x7), .x8(x8), .x9(x9),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .edge_o(edge_o), .de_o(de_o), .hs_o(hs_o),
    .vs_o(vs_o), .frame_max_o(fmax), .frame_max_vld(fvld)
  );

  filter_sobel_3x3 #(.DATA_WIDTH(W), .MAG_SHIFT(0)) dut_s0 (
    .clk(clk), .rst(rst), .bypass(bypass), .threshold(threshold),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5),
    .x6(x6), .x7(x7), .x8(x8), .x9(x9),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_s0), .edge_o(e_s0), .de_o(de_s0), .hs_o(hs_s0),
    .vs_o(vs_s0), .frame_max_o(fmax_s0), .frame_max_vld(fv_s0)
  );

  filter_sobel_3x3 #(.DATA_WIDTH(W), .MAG_SHIFT(3)) dut_s3 (
    .clk(clk), .rst(rst), .bypass(bypass), .threshold(threshold),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5),
    .x6(x6), .x7(x7), .x8(x8), .x9(x9),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_s3), .edge_o(e_s3), .de_o(de_s3), .hs_o(hs_s3),
    .vs_o(vs_s3), .frame_max_o(fmax_s3), .frame_max_vld(fv_s3)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fvld) pulses++;
  endtask

  task automatic set_win(input int l, input int mid, input int r);
    x1 = W'(l); x4 = W'(l); x7 = W'(l);
    x2 = W'(mid); x5 = W'(mid); x8 = W'(mid);
    x3 = W'(r); x6 = W'(r); x9 = W'(r);
  endtask

  // right column = v, rest 0 gives do_o = v with MAG_SHIFT=2
  task automatic set_val(input int v);
    set_win(0, 0, v);
  endtask

  task automatic run_frame(input int peak, input int exp_max);
    de_i = 0; vs_i = 0; set_val(0);
    repeat (6) step();
    pulses = 0;
    vs_i = 1; step();
    de_i = 1; set_val(200); step();
    set_val(peak); step();
    de_i = 0; set_val(2000); step();
    de_i = 1; set_val(50); step();
    vs_i = 0; set_val(3000); step();
    de_i = 0; set_val(0);
    check("frame_no_early_vld", pulses, 0);
    repeat (3) step();
    check("frame_vld_with_vs_fall", {31'd0, fvld}, 1);
    check("frame_vs_o_low", {31'd0, vs_o}, 0);
    check("frame_max", int'(fmax), exp_max);
    repeat (6) step();
    check("frame_pulse_count", pulses, 1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_do", int'(do_o), 0);
    check("rst_edge", {31'd0, edge_o}, 0);
    check("rst_de_hs_vs", {29'd0, de_o, hs_o, vs_o}, 0);
    check("rst_fmax", int'(fmax), 0);
    check("rst_fvld", {31'd0, fvld}, 0);
    rst = 0;

    set_win(100, 100, 100);
    x2 = 100; de_i = 1; threshold = 0;
    repeat (5) step();
    check("flat_do", int'(do_o), 0);
    check("flat_edge", {31'd0, edge_o}, 0);
    check("flat_de", {31'd0, de_o}, 1);

    de_i = 0;
    repeat (5) step();
    set_win(0, 0, 1000);
    threshold = 500; de_i = 1;
    step();
    de_i = 0;
    repeat (2) step();
    check("step_de_lat3", {31'd0, de_o}, 0);
    step();
    check("step_de_lat4", {31'd0, de_o}, 1);
    check("step_do", int'(do_o), 1000);
    check("step_edge", {31'd0, edge_o}, 1);
    step();
    check("step_edge_de0", {31'd0, edge_o}, 0);
    threshold = 1000; de_i = 1;
    repeat (4) step();
    check("step_eq_thr_do", int'(do_o), 1000);
    check("step_eq_thr_edge", {31'd0, edge_o}, 0);

    set_win(4095, 0, 0);
    threshold = 0;
    repeat (4) step();
    check("sat_shift2", int'(do_o), 4095);
    check("sat_shift0", int'(do_s0), 4095);
    check("sat_shift3", int'(do_s3), 2047);
    check("sat_edge", {31'd0, edge_o}, 1);

    set_win(0, 0, 1000);
    bypass = 1;
    for (int i = 0; i < 12; i++) begin
      x5 = W'(i + 7); hs_i = i[0]; de_i = (i % 3 != 2);
      step();
      if (i >= 3) begin
        check("byp_do", int'(do_o), i + 4);
        check("byp_edge", {31'd0, edge_o}, 0);
        check("byp_hs", {31'd0, hs_o}, (i - 3) % 2);
        check("byp_de", {31'd0, de_o}, ((i - 3) % 3 != 2) ? 1 : 0);
      end
    end
    bypass = 0; hs_i = 0;

    run_frame(1000, 1000);
    run_frame(300, 300);

    de_i = 0; vs_i = 0; set_val(0);
    repeat (6) step();
    vs_i = 1; de_i = 1; set_val(900);
    repeat (3) step();
    rst = 1; step(); rst = 0;
    check("mrst_do", int'(do_o), 0);
    check("mrst_vs_de", {30'd0, vs_o, de_o}, 0);
    check("mrst_fmax", int'(fmax), 0);
    pulses = 0;
    set_val(800);
    repeat (6) step();
    vs_i = 0; de_i = 0; set_val(0);
    repeat (10) step();
    check("mrst_no_vld", pulses, 0);
    run_frame(700, 700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
